// File: rtl/mem_bus_arbiter.sv
// Main-memory bus arbiter for D-cache, I-cache and debug bursts.
// Optional D/I round-robin when MEM_ARB_RR_EN is defined.
module mem_bus_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int DBG_WORDS  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_req,
  input  logic        i_req,
  input  logic        g_req,
  input  logic        d_we,
  input  logic        g_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] i_addr,
  input  logic [31:0] g_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] g_wdata,
  output logic        d_gnt,
  output logic        i_gnt,
  output logic        g_gnt,
  output logic        d_done,
  output logic        i_done,
  output logic        g_done,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic [3:0]  beat,
  output logic        busy,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [31:0] LINE_MASK =
    ~(32'(4 * LINE_WORDS) - 32'd1);
  localparam logic [3:0] LINE_LAST = 4'(LINE_WORDS - 1);
  localparam logic [3:0] DBG_LAST  = 4'(DBG_WORDS - 1);

  // own/pick bit order: [0]=D, [1]=I, [2]=G
  logic [1:0]  state;
  logic [2:0]  own;
  logic [2:0]  pick;
  logic        we_q;
  logic [31:0] base;
  logic [3:0]  beat_q;
  logic [3:0]  last;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        fav_i;
  logic        xfer;
  logic        held;

  assign xfer = (state == XFER);
  assign held = (state == XFER) || (state == DONE);
  assign last = own[2] ? DBG_LAST : LINE_LAST;

`ifdef MEM_ARB_RR_EN
  logic ptr;

  // After a cache burst completes, favour the other cache port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (state == DONE && (own[0] || own[1])) begin
      ptr <= own[0];
    end
  end

  assign fav_i = ptr;
`else
  assign fav_i = 1'b0;
`endif

  // Request selection: G absolute, then D/I by pointer or fixed
  always_comb begin
    pick = 3'b000;
    unique case (1'b1)
      g_req:
        pick = 3'b100;
      (!g_req && i_req && (!d_req || fav_i)):
        pick = 3'b010;
      (!g_req && d_req && !(i_req && fav_i)):
        pick = 3'b001;
      default:
        pick = 3'b000;
    endcase
  end

  // Burst sequencer: latch the winner, step beats, pulse done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      own    <= 3'b000;
      we_q   <= 1'b0;
      base   <= 32'd0;
      beat_q <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|pick) begin
            own    <= pick;
            we_q   <= pick[2] ? g_we : (pick[0] & d_we);
            base   <= pick[2] ? {g_addr[31:2], 2'b00}
                    : ((pick[0] ? d_addr : i_addr) & LINE_MASK);
            beat_q <= 4'd0;
            state  <= XFER;
          end
        end
        XFER: begin
          if (mem_ready) begin
            if (beat_q == last) begin
              state <= DONE;
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          beat_q <= 4'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered read return, one cycle after each accepted read beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      rvalid_q <= xfer && mem_ready && !we_q;
      if (xfer && mem_ready && !we_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign d_gnt  = own[0] & held;
  assign i_gnt  = own[1] & held;
  assign g_gnt  = own[2] & held;
  assign d_done = own[0] & (state == DONE);
  assign i_done = own[1] & (state == DONE);
  assign g_done = own[2] & (state == DONE);

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign beat   = beat_q;
  assign busy   = (state != IDLE);

  assign mem_valid = xfer;
  assign mem_we    = xfer & we_q;
  assign mem_addr  = xfer ? (base + {26'd0, beat_q, 2'b00})
                          : 32'd0;
  assign mem_wdata = !xfer  ? 32'd0
                   : own[2] ? g_wdata
                   : own[0] ? d_wdata
                   : 32'd0;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequences and shares one single-ported main-memory bus between three requesters: data-cache refill/writeback (D), instruction-cache refill (I), and the debug port (G).
- Sits between the two caches, the debug interface and main memory.
- Grants one requester at a time and runs its burst word by word.
- Provides a busy flag that the hazard unit folds into the stall logic.

Parameters:
- LINE_WORDS, 4, words per cache-line burst; power of two, 2..16.
- DBG_WORDS, 1, words per debug burst; fixed at 1 in this revision.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous assert, active-low
- d_req, i_req, g_req  in  1 each  burst request; held until the matching done
- d_we, g_we  in  1 each  1 = write burst; I port is read-only
- d_addr, i_addr, g_addr  in  32 each  byte address; cache addresses are aligned down to the line
- d_wdata, g_wdata  in  32 each  write word for the current beat
- d_gnt, i_gnt, g_gnt  out  1 each  owner indication; high from XFER entry to DONE exit
- d_done, i_done, g_done  out  1 each  one-cycle burst-complete pulse
- rvalid  out  1  read word valid for the current owner
- rdata  out  32  read word
- beat  out  4  index of the beat in progress; the owner drives wdata for this beat
- busy  out  1  high when the FSM is not in IDLE
- mem_valid  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  32  word address (byte address, bits [1:0] = 0)
- mem_wdata  out  32  memory write data
- mem_ready  in  1  memory accepts the beat; for reads, mem_rdata is valid in the same cycle
- mem_rdata  in  32  memory read data

Behaviour:
- Reset values: every output 0, FSM in IDLE, beat 0, priority pointer to D.
- Reset mid-burst aborts the burst immediately. No done is issued; the memory access is abandoned.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - Evaluate the requests every cycle.
  - Winner rule: g_req beats d_req, and d_req beats i_req.
  - On a winner: latch owner, we and base address. Base is addr & ~(4*LINE_WORDS-1) for D/I, and addr & ~3 for G.
  - Clear beat, then go to XFER.
  - The first mem_valid appears one cycle after the req is sampled.
- XFER:
  - mem_valid = 1.
  - mem_addr = base + 4*beat.
  - mem_we = latched we.
  - mem_wdata = owner's wdata, passed through combinationally.
  - The owner's gnt is high.
  - On mem_ready: if beat == last (LINE_WORDS-1 for D/I, 0 for G), go to DONE; otherwise increment beat.
  - Without mem_ready, hold all signals; there is no timeout.
- Read data path: rvalid and rdata are registered. They are asserted the cycle after each mem_ready on a read burst, carrying the captured mem_rdata. Writes never assert rvalid.
- DONE:
  - The owner's done is high for exactly one cycle. gnt stays high in DONE and drops when leaving it.
  - Return to IDLE.
  - The owner must drop req on the edge that samples done, so IDLE never re-grants a finished burst.
- Request changes: changes to req, we or addr during XFER are ignored. A dropped req does not abort the burst.
- Simultaneous requests in IDLE: the priority rule decides. Losers wait with req held; there is no starvation bound for I under fixed priority.
- Throughput: a minimum burst takes LINE_WORDS + 2 cycles (IDLE sample, LINE_WORDS beats, DONE).
- busy = (state != IDLE).

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - G keeps absolute priority.
  - D and I alternate using a one-bit pointer.
  - The pointer flips to favour the other cache port whenever a D or I burst reaches DONE.
  - If only one of D/I requests, it wins regardless of the pointer.
  - The pointer resets to favour D.
- Undefined: fixed priority G > D > I, and the pointer logic is absent.

Test Plan:
- D read burst, d_addr=0x1004, mem_ready always 1, mem_rdata = address:
  - mem_addr sequence is 0x1000, 0x1004, 0x1008, 0x100C.
  - rvalid data is the same sequence, each word one cycle after its beat.
  - d_done pulses once, 6 cycles after the req is sampled.
- D write burst with mem_ready low for 3 cycles on beat 2:
  - beat holds at 2 and mem_addr holds at base+8 for those 3 cycles.
  - 4 writes occur in total, d_done fires once, and rvalid stays 0.
- d_req and i_req both raised in the same cycle with G idle, fixed priority:
  - D is served first.
  - I gnt rises 1 cycle after d_done clears, with i_addr 0x2000 bursting 0x2000..0x200C.
- G write 0xDEADBEEF to 0x300 while i_req is also high:
  - G wins, giving a single beat with mem_addr=0x300, mem_we=1.
  - g_done pulses 3 cycles after the req is sampled; I is granted next.
- rst driven low during beat 1 of an I burst:
  - All outputs go to 0 asynchronously and the FSM is in IDLE.
  - After release with i_req still high, the burst restarts from beat 0.
- With MEM_ARB_RR_EN, D and I requesting continuously for 4 bursts: grant order is D, I, D, I.
